// File: rtl/act_pwq_if.sv
// act_pwq_if: sample stream into and out of act_pwq_pipe (valid/ready on both sides).
interface act_pwq_if #(parameter int DATA_W = 20);
  logic                     in_valid, in_ready, in_last;
  logic [1:0]               in_mode;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid, out_ready, out_last;
  logic signed [DATA_W-1:0] out_data;
  modport master (output in_valid, in_data, in_mode, in_last, out_ready,
                  input in_ready, out_valid, out_data, out_last);
  modport slave (input in_valid, in_data, in_mode, in_last, out_ready,
                 output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/act_pwq_pipe.sv
// act_pwq_pipe: 4-stage piecewise-quadratic activation (tanh/sigmoid/ReLU/bypass) with valid/ready.
// ACT_ROUND_EN: round-to-nearest on the Q16 -> Q(FRAC_W) shift instead of truncation.
module act_pwq_pipe #(
  parameter int DATA_W = 20,
  parameter int FRAC_W = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  act_pwq_if.slave    bus,
  output logic        batch_done_o,
  output logic [15:0] out_count_o
);
  localparam int PW = 2*DATA_W + 18;
  localparam logic signed [DATA_W-1:0] MAXP = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] MINN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] ONE  = DATA_W'(1) << FRAC_W;
  localparam logic signed [DATA_W-1:0] FOUR = DATA_W'(4) << FRAC_W;
`ifdef ACT_ROUND_EN
  localparam logic signed [PW-1:0] RND = PW'(1) << (15 - FRAC_W);
`else
  localparam logic signed [PW-1:0] RND = '0;
`endif
  typedef struct packed {
    logic              v;
    logic              last;
    logic [1:0]        mode;
    logic [DATA_W-1:0] x;
  } tag_t;
  tag_t t0_d, t0_q, t1_q, t2_q;
  logic adv, hs, v3_q, last3_q, done_q;
  logic sgn0_q, sat0_q, sgn1_q, sat1_q, sgn2_q;
  logic [1:0] seg0_q, seg1_q;
  logic [15:0] cnt_q;
  logic signed [DATA_W-1:0] xs, a_d, a0_q, y_d, y2_q, yt, sg, r_d, r3_q;
  logic signed [17:0] ca, cb, cc;
  logic signed [PW-1:0] tb_d, ta_d, tb1_q, ta1_q, y16, ys;
  assign adv          = !v3_q || bus.out_ready;
  assign bus.in_ready = adv;
  assign t0_d = '{v: bus.in_valid, last: bus.in_valid && bus.in_last, mode: bus.in_mode, x: bus.in_data};
  // S0: fold sigmoid onto tanh(x/2), take magnitude with saturation of the most negative value
  assign xs  = bus.in_mode == 2'b01 ? bus.in_data >>> 1 : bus.in_data;
  assign a_d = xs == MINN ? MAXP : xs[DATA_W-1] ? -xs : xs;
  assign ca = seg0_q == 2'd0 ? 18'sd21463 : seg0_q == 2'd1 ? 18'sd11076 : seg0_q == 2'd2 ? 18'sd1848 : 18'sd256;
  assign cb = seg0_q == 2'd0 ? 18'sd71939 : seg0_q == 2'd1 ? 18'sd46013 : seg0_q == 2'd2 ? 18'sd11161 : 18'sd2051;
  assign cc = seg1_q == 2'd0 ? -18'sd249  : seg1_q == 2'd1 ? 18'sd15231 : seg1_q == 2'd2 ? 18'sd48300 : 18'sd61361;
  assign tb_d = (PW'(cb) * PW'(a0_q)) >>> FRAC_W;
  assign ta_d = (PW'(ca) * PW'(a0_q) * PW'(a0_q)) >>> (2*FRAC_W);
  assign y16  = tb1_q - ta1_q + PW'(cc) + RND;
  assign ys   = y16 >>> (16 - FRAC_W);
  assign y_d  = sat1_q ? ONE : ys[PW-1] ? '0 : ys > PW'(ONE) ? ONE : ys[DATA_W-1:0];
  assign yt   = sgn2_q ? -y2_q : y2_q;
  assign sg   = (yt + ONE) >>> 1;
  assign r_d  = t2_q.mode == 2'b00 ? yt : t2_q.mode == 2'b01 ? sg :
                t2_q.mode == 2'b10 && t2_q.x[DATA_W-1] ? '0 : t2_q.x;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      t0_q <= '0; t1_q <= '0; t2_q <= '0; v3_q <= 1'b0; last3_q <= 1'b0;
      sgn0_q <= 1'b0; sat0_q <= 1'b0; seg0_q <= '0; a0_q <= '0;
      sgn1_q <= 1'b0; sat1_q <= 1'b0; seg1_q <= '0; tb1_q <= '0; ta1_q <= '0;
      sgn2_q <= 1'b0; y2_q <= '0; r3_q <= '0;
    end else if (adv) begin
      t0_q <= t0_d; sgn0_q <= xs[DATA_W-1]; sat0_q <= a_d >= FOUR;
      seg0_q <= a_d[FRAC_W+1:FRAC_W]; a0_q <= a_d;
      t1_q <= t0_q; sgn1_q <= sgn0_q; sat1_q <= sat0_q; seg1_q <= seg0_q;
      tb1_q <= tb_d; ta1_q <= ta_d;
      t2_q <= t1_q; sgn2_q <= sgn1_q; y2_q <= y_d;
      v3_q <= t2_q.v; last3_q <= t2_q.last; r3_q <= r_d;
    end
  assign hs = v3_q && bus.out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= hs && last3_q;
      if (hs) cnt_q <= last3_q ? '0 : cnt_q + 16'd1;
    end
  assign bus.out_valid = v3_q;
  assign bus.out_last  = last3_q;
  assign bus.out_data  = r3_q;
  assign batch_done_o  = done_q;
  assign out_count_o   = cnt_q;
endmodule

// File: tb/tb_act_pwq_pipe.sv
// tb_act_pwq_pipe: directed vectors with hand-computed results for act_pwq_pipe.
module tb_act_pwq_pipe;
  localparam int DW = 20;
  localparam int NV = 17;
  logic clk, rst_n, batch_done;
  logic [15:0] out_count;
  int total = 0, bad = 0, n_out = 0, done_n = 0;
  int exp_q[$];
  string tag_q[$];
  act_pwq_if #(.DATA_W(DW)) bus();
  act_pwq_pipe #(.DATA_W(DW), .FRAC_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .batch_done_o(batch_done), .out_count_o(out_count)
  );
  int vx[NV] = '{64, -64, 128, 0, 256, 320, -524288, 32, -200, 0, 128, -1000, -128, -192, 160, -192, 524287};
  int vm[NV] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 3, 3};
`ifdef ACT_ROUND_EN
  int ve[NV] = '{49, -49, 62, 0, 64, 64, -64, 30, -64, 32, 56, 0, 7, 0, 160, -192, 524287};
`else
  int ve[NV] = '{48, -48, 61, 0, 64, 64, -64, 29, -63, 32, 56, 0, 8, 0, 160, -192, 524287};
`endif
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (batch_done) done_n++;
    if (rst_n && bus.out_valid && bus.out_ready) begin
      n_out++;
      if (exp_q.size() == 0) chk("extra_out", int'(bus.out_data), -999999);
      else chk(tag_q.pop_front(), int'(bus.out_data), exp_q.pop_front());
    end
  end
  task automatic send(input int x, input int m, input logic l, input int e, input string t);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = x[DW-1:0];
    bus.in_mode  = m[1:0];
    bus.in_last  = l;
    @(negedge clk);
    while (!bus.in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("in_timeout", n, 0);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      n++;
      @(posedge clk); #1;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask
  task automatic latency(input int x, input int m, input int e, input string t);
    int n = 0;
    send(x, m, 1'b0, e, t);
    do begin
      @(negedge clk);
      n++;
    end while (!bus.out_valid && n < 20);
    chk({t, "_lat"}, n, 4);
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: time=%0t limit=200000", $time);
    $fatal(1);
  end
  initial begin
    int sv_cnt;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_mode = '0; bus.in_last = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_vld", int'(bus.out_valid), 0);
    chk("rst_data", int'(bus.out_data), 0);
    chk("rst_last", int'(bus.out_last), 0);
    chk("rst_done", int'(batch_done), 0);
    chk("rst_cnt", int'(out_count), 0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_rdy", int'(bus.in_ready), 1);
    for (int i = 0; i < NV; i++) send(vx[i], vm[i], 1'b0, ve[i], $sformatf("vec%0d", i));
    drain();
    chk("vec_count", n_out, NV);
    latency(-192, 3, -192, "byp");
    drain();
    latency(160, 2, 160, "relu");
    drain();
    latency(-192, 2, 0, "relu_neg");
    drain();
    n_out = 0;
    fork
      for (int i = 0; i < 10; i++) send(100 + i, 3, 1'b0, 100 + i, $sformatf("bp%0d", i));
      for (int k = 0; k < 20; k++) begin
        bus.out_ready = (k < 5 || k > 12);
        if (k == 10) begin
          @(negedge clk);
          chk("bp_rdy", int'(bus.in_ready), 0);
          chk("bp_vld", int'(bus.out_valid), 1);
          chk("bp_hold", int'(bus.out_data), 101);
        end
        @(posedge clk); #1;
      end
    join
    bus.out_ready = 1'b1;
    drain();
    chk("bp_count", n_out, 10);
    for (int i = 0; i < 3; i++) send(7 + i, 3, 1'b0, 7 + i, "rst_flight");
    rst_n = 1'b0;
    exp_q.delete();
    tag_q.delete();
    #2;
    chk("mid_vld", int'(bus.out_valid), 0);
    chk("mid_data", int'(bus.out_data), 0);
    chk("mid_cnt", int'(out_count), 0);
    chk("mid_done", int'(batch_done), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    sv_cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.out_valid) sv_cnt++;
    end
    chk("stale_out", sv_cnt, 0);
    chk("stale_done", done_n, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) send(20 + i, 3, i == 6, 20 + i, $sformatf("bat%0d", i));
    sv_cnt = 0;
    while (!(bus.out_valid && bus.out_last) && sv_cnt < 50) begin
      sv_cnt++;
      @(negedge clk);
    end
    chk("bat_cnt_pre", int'(out_count), 6);
    chk("bat_done_pre", int'(batch_done), 0);
    @(negedge clk);
    chk("bat_done", int'(batch_done), 1);
    chk("bat_cnt_post", int'(out_count), 0);
    @(negedge clk);
    chk("bat_done_1cyc", int'(batch_done), 0);
    drain();
    chk("bat_pulses", done_n, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
